fwd_hazard_ctrl: RTL and testbench

//  Parametrised forwarding and load-use hazard controller for the pipelined core.

---
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller, driven by a tag pipeline that tracks EX..EX+FWD_DEPTH.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_EN.
module fwd_hazard_ctrl #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    localparam int SELW      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [AW-1:0]           id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_is_load,
    input  logic [NUM_SRC*AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    output logic [NUM_SRC*SELW-1:0] fwd_sel,
    output logic                    load_use_stall,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_fwd_cnt
);

    logic                    tag_valid_q [0:FWD_DEPTH];
    logic [AW-1:0]           tag_rd_q    [0:FWD_DEPTH];
    logic                    tag_we_q    [0:FWD_DEPTH];
    logic                    tag_ld_q    [0:FWD_DEPTH];
    logic [NUM_SRC*SELW-1:0] fwd_sel_q, fwd_sel_d;
    logic [NUM_SRC*SELW-1:0] cand_sel;
    logic [NUM_SRC-1:0]      src_stall;
    logic                    flush_eff;
    logic                    stall;
    logic                    issue;

    // Stages are scanned from oldest to youngest so the nearest producer overwrites older matches.
    always_comb begin
        cand_sel  = '0;
        src_stall = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 0; k--) begin
                if (tag_valid_q[k] && tag_we_q[k] && (tag_rd_q[k] != '0) &&
                    (tag_rd_q[k] == id_rs[i*AW +: AW]) && id_rs_used[i]) begin
                    cand_sel[i*SELW +: SELW] = (k + 1 <= FWD_DEPTH) ? SELW'(k + 1) : '0;
                    src_stall[i]             = tag_ld_q[k] && (k + 1 < LOAD_STAGE);
                end
            end
        end
    end

    // A flush raised while frozen has no effect, so the stall stays visible during hold.
    always_comb begin
        flush_eff = flush & ~hold;
        stall     = id_valid & ~flush_eff & (|src_stall);
        issue     = id_valid & ~flush_eff & ~stall;
        fwd_sel_d = issue ? cand_sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                tag_valid_q[k] <= 1'b0;
                tag_rd_q[k]    <= '0;
                tag_we_q[k]    <= 1'b0;
                tag_ld_q[k]    <= 1'b0;
            end
            fwd_sel_q <= '0;
        end else if (!hold) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                tag_valid_q[k] <= tag_valid_q[k-1];
                tag_rd_q[k]    <= tag_rd_q[k-1];
                tag_we_q[k]    <= tag_we_q[k-1];
                tag_ld_q[k]    <= tag_ld_q[k-1];
            end
            tag_valid_q[0] <= issue;
            tag_rd_q[0]    <= issue ? id_rd : '0;
            tag_we_q[0]    <= issue & id_reg_write;
            tag_ld_q[0]    <= issue & id_is_load;
            fwd_sel_q      <= fwd_sel_d;
        end
    end

    assign fwd_sel        = fwd_sel_q;
    assign load_use_stall = stall;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (!hold) begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
            if (issue && (|cand_sel) && (fwd_cnt_q != 32'hFFFF_FFFF)) fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl at default parameters; expectations are hand-computed.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_is_load;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [3:0]  fwd_sel;
    logic        load_use_stall;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;

    int total = 0;
    int bad   = 0;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fwd_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .id_rs          (id_rs),
        .id_rs_used     (id_rs_used),
        .fwd_sel        (fwd_sel),
        .load_use_stall (load_use_stall),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                          input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
        id_valid     = v;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        id_rs        = {rs1, rs0};
        id_rs_used   = used;
    endtask

    task automatic producer(input logic [4:0] rd, input logic ld);
        id_set(1'b1, rd, 1'b1, ld, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic nop();
        id_set(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic drain();
        nop();
        repeat (3) cyc();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        nop();
        #3;
        chk("rst_fwd", {28'd0, fwd_sel}, 32'd0);
        chk("rst_stall", {31'd0, load_use_stall}, 32'd0);
        chk("rst_pstall", perf_stall_cnt, 32'd0);
        chk("rst_pfwd", perf_fwd_cnt, 32'd0);
        cyc();
        rst = 1'b0;

        // EX/MEM forward
        producer(5'd5, 1'b0);
        #1 chk("p5_stall", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("p5_fwd", {28'd0, fwd_sel}, 32'd0);
        id_set(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd1, 2'b11);
        #1 chk("exmem_stall", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("exmem_fwd", {28'd0, fwd_sel}, 32'h1);
        nop();
        cyc();
        chk("nop_fwd", {28'd0, fwd_sel}, 32'd0);
        cyc(); cyc();

        // MEM/WB forward with one nop
        producer(5'd5, 1'b0); cyc();
        nop(); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        cyc();
        chk("memwb_fwd", {28'd0, fwd_sel}, 32'h2);

        // two nops: producer in last tag stage -> regfile
        drain();
        producer(5'd5, 1'b0); cyc();
        nop(); cyc(); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        cyc();
        chk("oldest_fwd", {28'd0, fwd_sel}, 32'd0);

        // three nops: producer gone
        drain();
        producer(5'd5, 1'b0); cyc();
        nop(); cyc(); cyc(); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        cyc();
        chk("gone_fwd", {28'd0, fwd_sel}, 32'd0);

        // load-use: one stall cycle then both sources from stage 2
        drain();
        producer(5'd7, 1'b1); cyc();
        id_set(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11);
        #1 chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
        cyc();
        chk("lu_bubble", {28'd0, fwd_sel}, 32'd0);
        chk("lu_stall_end", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("lu_fwd", {28'd0, fwd_sel}, 32'hA);
        chk("lu_pstall", perf_stall_cnt, PERF ? 32'd1 : 32'd0);

        // nearest producer wins
        drain();
        producer(5'd3, 1'b0); cyc();
        producer(5'd3, 1'b0); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 2'b11);
        cyc();
        chk("nearest_fwd", {28'd0, fwd_sel}, 32'h1);

        // x0 never forwards or stalls
        drain();
        producer(5'd0, 1'b0); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
        #1 chk("x0_stall", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("x0_fwd", {28'd0, fwd_sel}, 32'd0);
        producer(5'd0, 1'b1); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
        #1 chk("x0_ld_stall", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("x0_ld_fwd", {28'd0, fwd_sel}, 32'd0);

        // non-writing producer invisible
        drain();
        id_set(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 2'b11);
        cyc();
        chk("nowrite_fwd", {28'd0, fwd_sel}, 32'd0);

        // unused sources: no select, no stall
        drain();
        producer(5'd7, 1'b1); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 2'b00);
        #1 chk("unused_stall", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("unused_fwd", {28'd0, fwd_sel}, 32'd0);

        // two sources from different stages
        drain();
        producer(5'd3, 1'b0); cyc();
        producer(5'd4, 1'b0); cyc();
        id_set(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd4, 2'b11);
        cyc();
        chk("split_fwd", {28'd0, fwd_sel}, 32'h6);

        // hold mid-stall with flush ignored
        drain();
        producer(5'd2, 1'b0); cyc();
        id_set(1'b1, 5'd7, 1'b1, 1'b1, 5'd2, 5'd0, 2'b01); cyc();
        chk("hold_pre_fwd", {28'd0, fwd_sel}, 32'h1);
        id_set(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd1, 2'b01);
        hold = 1'b1; flush = 1'b1;
        #1 chk("hold_stall0", {31'd0, load_use_stall}, 32'd1);
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk("hold_fwd", {28'd0, fwd_sel}, 32'h1);
            chk("hold_stall", {31'd0, load_use_stall}, 32'd1);
        end
        hold = 1'b0; flush = 1'b0;
        cyc();
        chk("unhold_bubble", {28'd0, fwd_sel}, 32'd0);
        chk("unhold_stall", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("unhold_fwd", {28'd0, fwd_sel}, 32'h2);
        chk("pstall_total", perf_stall_cnt, PERF ? 32'd2 : 32'd0);
        chk("pfwd_total", perf_fwd_cnt, PERF ? 32'd7 : 32'd0);

        // flush with hold low suppresses stall and issue
        drain();
        producer(5'd7, 1'b1); cyc();
        id_set(1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01);
        flush = 1'b1;
        #1 chk("flush_stall", {31'd0, load_use_stall}, 32'd0);
        cyc();
        chk("flush_fwd", {28'd0, fwd_sel}, 32'd0);
        flush = 1'b0;

        // asynchronous reset during a stall
        drain();
        producer(5'd2, 1'b0); cyc();
        id_set(1'b1, 5'd7, 1'b1, 1'b1, 5'd2, 5'd0, 2'b01); cyc();
        id_set(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01);
        #1 chk("arst_pre_stall", {31'd0, load_use_stall}, 32'd1);
        chk("arst_pre_fwd", {28'd0, fwd_sel}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", {31'd0, load_use_stall}, 32'd0);
        chk("arst_fwd", {28'd0, fwd_sel}, 32'd0);
        chk("arst_pstall", perf_stall_cnt, 32'd0);
        chk("arst_pfwd", perf_fwd_cnt, 32'd0);
        #1 rst = 1'b0;
        cyc();
        chk("post_rst_fwd", {28'd0, fwd_sel}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
